// File: rtl/dma_job_queue.sv
// dma_job_queue: request FIFO between the register frontend and the N-D midend.
// Each accepted job gets a transfer ID. IDs run 1 .. 2^IdWidth-1 and then wrap
// back to 1; ID 0 is reserved and means "nothing done". Retirements come from the
// midend response stream and are counted against the outstanding-job counter.
module dma_job_queue #(
    parameter int Depth          = 4,
    parameter int ReqWidth       = 256,
    parameter int IdWidth        = 16,
    parameter int MaxOutstanding = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ReqWidth-1:0]        fe_req_i,
    input  logic                       fe_valid_i,
    output logic                       fe_ready_o,
    output logic [ReqWidth-1:0]        me_req_o,
    output logic                       me_valid_o,
    input  logic                       me_ready_i,
    input  logic                       me_rsp_valid_i,
    output logic                       me_rsp_ready_o,
    output logic [IdWidth-1:0]         next_id_o,
    output logic [IdWidth-1:0]         done_id_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic                       busy_o,
    output logic                       err_o,
    input  logic                       clear_err_i
);

    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = PtrW + 1;
    localparam int OutW = $clog2(MaxOutstanding + 1);

    // Advance a transfer ID, skipping the reserved value 0 on wrap.
    function automatic logic [IdWidth-1:0] id_inc(input logic [IdWidth-1:0] id);
        logic [IdWidth-1:0] nxt;
        if (id == {IdWidth{1'b1}}) begin
            nxt = IdWidth'(1);
        end else begin
            nxt = id + IdWidth'(1);
        end
        return nxt;
    endfunction

    logic [ReqWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]     level_q, level_d;
    logic [OutW-1:0]     outst_q, outst_d;
    logic [IdWidth-1:0]  next_id_q, next_id_d;
    logic [IdWidth-1:0]  done_id_q, done_id_d;
    logic                err_q, err_d;

    logic full_s;
    logic empty_s;
    logic can_accept_s;
    logic push_s;
    logic pop_s;
    logic retire_ok_s;
    logic retire_bad_s;

    // Handshake decode; ready depends only on registered state (and reset), never on me_ready_i.
    always_comb begin
        full_s       = (level_q == LvlW'(Depth));
        empty_s      = (level_q == {LvlW{1'b0}});
        can_accept_s = !full_s && (outst_q < OutW'(MaxOutstanding));
        fe_ready_o   = !rst_i && can_accept_s;
        push_s       = fe_valid_i && fe_ready_o;
        pop_s        = !empty_s && me_ready_i;
        retire_ok_s  = me_rsp_valid_i && (outst_q != {OutW{1'b0}});
        retire_bad_s = me_rsp_valid_i && (outst_q == {OutW{1'b0}});
    end

    // Next-state for pointers, level, outstanding count, IDs and sticky error.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        outst_d   = outst_q;
        next_id_d = next_id_q;
        done_id_d = done_id_q;
        err_d     = err_q;

        if (push_s) begin
            wr_ptr_d  = wr_ptr_q + PtrW'(1);
            next_id_d = id_inc(next_id_q);
        end else begin
            wr_ptr_d  = wr_ptr_q;
            next_id_d = next_id_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase

        case ({push_s, retire_ok_s})
            2'b10:   outst_d = outst_q + OutW'(1);
            2'b01:   outst_d = outst_q - OutW'(1);
            default: outst_d = outst_q;
        endcase

        if (retire_ok_s) begin
            done_id_d = id_inc(done_id_q);
        end else begin
            done_id_d = done_id_q;
        end

        // A fresh illegal retire wins over a simultaneous clear.
        if (retire_bad_s) begin
            err_d = 1'b1;
        end else if (clear_err_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Control and bookkeeping registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= {PtrW{1'b0}};
            rd_ptr_q  <= {PtrW{1'b0}};
            level_q   <= {LvlW{1'b0}};
            outst_q   <= {OutW{1'b0}};
            next_id_q <= IdWidth'(1);
            done_id_q <= {IdWidth{1'b0}};
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            outst_q   <= outst_d;
            next_id_q <= next_id_d;
            done_id_q <= done_id_d;
            err_q     <= err_d;
        end
    end

    // Payload storage; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= fe_req_i;
        end
    end

    // Output mapping from registered state.
    always_comb begin
        me_valid_o     = !empty_s;
        if (empty_s) begin
            me_req_o = {ReqWidth{1'b0}};
        end else begin
            me_req_o = mem_q[rd_ptr_q];
        end
        me_rsp_ready_o = 1'b1;
        next_id_o      = next_id_q;
        done_id_o      = done_id_q;
        level_o        = level_q;
        busy_o         = (outst_q != {OutW{1'b0}});
        err_o          = err_q;
    end

endmodule

// File: tb/tb_dma_job_queue.sv
// Self-checking bench for dma_job_queue. A behavioural reference model plus a
// payload scoreboard queue predicts every output each cycle. IdWidth is reduced
// to 4 so the ID wrap (15 -> 1) is reachable in a short run.
module tb_dma_job_queue;

    localparam int Depth  = 4;
    localparam int ReqW   = 256;
    localparam int IdW    = 4;
    localparam int MaxOut = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [ReqW-1:0]   fe_req_i;
    logic              fe_valid_i;
    logic              fe_ready_o;
    logic [ReqW-1:0]   me_req_o;
    logic              me_valid_o;
    logic              me_ready_i;
    logic              me_rsp_valid_i;
    logic              me_rsp_ready_o;
    logic [IdW-1:0]    next_id_o;
    logic [IdW-1:0]    done_id_o;
    logic [2:0]        level_o;
    logic              busy_o;
    logic              err_o;
    logic              clear_err_i;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // reference model state
    logic [ReqW-1:0] sb_q[$];
    int              out_m;
    logic [IdW-1:0]  next_m;
    logic [IdW-1:0]  done_m;
    logic            err_m;

    dma_job_queue #(
        .Depth(Depth), .ReqWidth(ReqW), .IdWidth(IdW), .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fe_req_i(fe_req_i), .fe_valid_i(fe_valid_i), .fe_ready_o(fe_ready_o),
        .me_req_o(me_req_o), .me_valid_o(me_valid_o), .me_ready_i(me_ready_i),
        .me_rsp_valid_i(me_rsp_valid_i), .me_rsp_ready_o(me_rsp_ready_o),
        .next_id_o(next_id_o), .done_id_o(done_id_o), .level_o(level_o),
        .busy_o(busy_o), .err_o(err_o), .clear_err_i(clear_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [ReqW-1:0] got, input logic [ReqW-1:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [IdW-1:0] nxt_id(input logic [IdW-1:0] id);
        return (id == 4'd15) ? 4'd1 : id + 4'd1;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        out_m  = 0;
        next_m = 4'd1;
        done_m = 4'd0;
        err_m  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_fe_ready", ReqW'(fe_ready_o), ReqW'(0));
        check("rst_me_valid", ReqW'(me_valid_o), ReqW'(0));
        check("rst_me_req",   me_req_o,          ReqW'(0));
        check("rst_level",    ReqW'(level_o),    ReqW'(0));
        check("rst_next_id",  ReqW'(next_id_o),  ReqW'(1));
        check("rst_done_id",  ReqW'(done_id_o),  ReqW'(0));
        check("rst_busy",     ReqW'(busy_o),     ReqW'(0));
        check("rst_err",      ReqW'(err_o),      ReqW'(0));
        check("rsp_ready",    ReqW'(me_rsp_ready_o), ReqW'(1));
    endtask

    // Called at a negedge with inputs already set: compare, advance model, move to next negedge.
    task automatic step();
        logic exp_ready, push, pop, legal, illegal;
        int   lvl;
        #1;
        lvl       = sb_q.size();
        exp_ready = (lvl < Depth) && (out_m < MaxOut);
        check("fe_ready", ReqW'(fe_ready_o), ReqW'(exp_ready));
        check("me_valid", ReqW'(me_valid_o), ReqW'(lvl != 0));
        check("me_req",   me_req_o, (lvl != 0) ? sb_q[0] : ReqW'(0));
        check("level",    ReqW'(level_o),   ReqW'(lvl));
        check("next_id",  ReqW'(next_id_o), ReqW'(next_m));
        check("done_id",  ReqW'(done_id_o), ReqW'(done_m));
        check("busy",     ReqW'(busy_o),    ReqW'(out_m != 0));
        check("err",      ReqW'(err_o),     ReqW'(err_m));
        push    = fe_valid_i && exp_ready;
        pop     = (lvl != 0) && me_ready_i;
        legal   = me_rsp_valid_i && (out_m > 0);
        illegal = me_rsp_valid_i && (out_m == 0);
        if (pop)  void'(sb_q.pop_front());
        if (push) begin
            sb_q.push_back(fe_req_i);
            next_m = nxt_id(next_m);
        end
        out_m = out_m + (push ? 1 : 0) - (legal ? 1 : 0);
        if (legal) done_m = nxt_id(done_m);
        if (illegal) err_m = 1'b1;
        else if (clear_err_i) err_m = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic drive(input logic fv, input logic mr, input logic rv, input logic ce);
        fe_valid_i     = fv;
        me_ready_i     = mr;
        me_rsp_valid_i = rv;
        clear_err_i    = ce;
        fe_req_i       = {8{$urandom()}};
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (out_m > 0 || sb_q.size() > 0); i++) begin
            drive(1'b0, 1'b1, out_m > 0, 1'b0);
            step();
        end
        check("drained", ReqW'(out_m), ReqW'(0));
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        #1 check_reset_outputs();
        rst_i = 1'b0;

        // single job with A5 pattern
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        fe_req_i = {32{8'hA5}};
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("single_done_id", ReqW'(done_id_o), ReqW'(1));

        // fill to full under backpressure, extra requests stall, then drain in order
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        check("full_level", ReqW'(level_o), ReqW'(4));
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            step();
        end
        drain();

        // steady push+pop+retire at level 2
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            step();
        end
        check("steady_level", ReqW'(level_o), ReqW'(2));
        drain();

        // ID wrap: many jobs through push/pop/retire
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, out_m > 0, 1'b0);
            step();
        end
        drain();

        // outstanding limit with empty FIFO
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        check("maxout_ready", ReqW'(fe_ready_o), ReqW'(0));
        check("maxout_empty", ReqW'(level_o), ReqW'(0));
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        drain();

        // illegal retire, clear, clear racing a new illegal retire
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        #2 rst_i = 1'b1;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, out_m > 0, 1'b0);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
